// File: rtl/sid_envelope.sv
// Purpose : SID ADSR envelope generator plus amplitude stage feeding the filter/mixer.
// Latency : env advances on CLKen rate ticks; VOICE_IN/env -> OUTPUT is 2 CLK.
// Backpressure: none; OUTPUT is a free-running sample every CLK.
//
// Ports:
//   CLK       master clock
//   RST       synchronous, active-high reset
//   CLKen     1 MHz enable; envelope logic advances only when high
//   WR        register write strobe (BASE_ADDR+4 control, +5 AD, +6 SR)
//   ADDR      register address
//   DATA      write data
//   VOICE_IN  unsigned 12-bit waveform, centre 'h800
//   ENV_OUT   current 8-bit envelope level
//   OUTPUT    signed 12-bit amplitude-scaled sample
module sid_envelope #(
    parameter int BASE_ADDR = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CLKen,
    input  logic        WR,
    input  logic [4:0]  ADDR,
    input  logic [7:0]  DATA,
    input  logic [11:0] VOICE_IN,
    output logic [7:0]  ENV_OUT,
    output logic [11:0] OUTPUT
);

    localparam logic [1:0] ST_ATTACK  = 2'd0;
    localparam logic [1:0] ST_DECSUS  = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [4:0] ADDR_CTRL = 5'(BASE_ADDR + 4);
    localparam logic [4:0] ADDR_AD   = 5'(BASE_ADDR + 5);
    localparam logic [4:0] ADDR_SR   = 5'(BASE_ADDR + 6);

    logic        gate;
    logic        gate_prev;
    logic [3:0]  atk;
    logic [3:0]  dec;
    logic [3:0]  sus;
    logic [3:0]  rel;
    logic [1:0]  state;
    logic [14:0] rate_cnt;
    logic [4:0]  exp_cnt;
    logic [7:0]  env;

    logic [3:0]  rate_sel;
    logic        rate_tick;
    logic [4:0]  exp_period;
    logic        exp_step;

    // Terminal count (period - 1) of the rate counter for each 4-bit rate.
    function automatic logic [14:0] rate_period_m1(input logic [3:0] idx);
        case (idx)
            4'd0:    rate_period_m1 = 15'd8;
            4'd1:    rate_period_m1 = 15'd31;
            4'd2:    rate_period_m1 = 15'd62;
            4'd3:    rate_period_m1 = 15'd94;
            4'd4:    rate_period_m1 = 15'd148;
            4'd5:    rate_period_m1 = 15'd219;
            4'd6:    rate_period_m1 = 15'd266;
            4'd7:    rate_period_m1 = 15'd312;
            4'd8:    rate_period_m1 = 15'd391;
            4'd9:    rate_period_m1 = 15'd976;
            4'd10:   rate_period_m1 = 15'd1953;
            4'd11:   rate_period_m1 = 15'd3125;
            4'd12:   rate_period_m1 = 15'd3906;
            4'd13:   rate_period_m1 = 15'd11719;
            4'd14:   rate_period_m1 = 15'd19531;
            default: rate_period_m1 = 15'd31250;
        endcase
    endfunction

    always_comb begin
        rate_sel = rel;
        case (state)
            ST_ATTACK: rate_sel = atk;
            ST_DECSUS: rate_sel = dec;
            default:   rate_sel = rel;
        endcase
    end

    // Equality only: a period lowered below the running count lets the
    // counter run on through 'h7FFF and wrap, as the original chip does.
    assign rate_tick = (rate_cnt == rate_period_m1(rate_sel));

    // Piecewise-exponential slowdown of decay/release as the level falls.
    always_comb begin
        if (env >= 8'd94)      exp_period = 5'd1;
        else if (env >= 8'd55) exp_period = 5'd2;
        else if (env >= 8'd27) exp_period = 5'd4;
        else if (env >= 8'd15) exp_period = 5'd8;
        else if (env >= 8'd7)  exp_period = 5'd16;
        else if (env >= 8'd1)  exp_period = 5'd30;
        else                   exp_period = 5'd1;
    end

    // >= so a shorter period taking over mid-count still wraps promptly.
    assign exp_step = ((exp_cnt + 5'd1) >= exp_period);

    always_ff @(posedge CLK) begin
        if (RST) begin
            gate      <= 1'b0;
            gate_prev <= 1'b0;
            atk       <= 4'd0;
            dec       <= 4'd0;
            sus       <= 4'd0;
            rel       <= 4'd0;
            state     <= ST_RELEASE;
            rate_cnt  <= 15'd0;
            exp_cnt   <= 5'd0;
            env       <= 8'd0;
        end else begin
            if (WR) begin
                if (ADDR == ADDR_CTRL) gate <= DATA[0];
                if (ADDR == ADDR_AD) begin
                    atk <= DATA[7:4];
                    dec <= DATA[3:0];
                end
                if (ADDR == ADDR_SR) begin
                    sus <= DATA[7:4];
                    rel <= DATA[3:0];
                end
            end

            if (CLKen) begin
                gate_prev <= gate;
                rate_cnt  <= rate_tick ? 15'd0 : rate_cnt + 15'd1;

                // Gate edges take priority over a coincident rate tick.
                if (gate && !gate_prev) begin
                    state   <= ST_ATTACK;
                    exp_cnt <= 5'd0;
                end else if (!gate && gate_prev) begin
                    state <= ST_RELEASE;
                end else if (rate_tick) begin
                    case (state)
                        ST_ATTACK: begin
                            if (env != 8'hFF) env <= env + 8'd1;
                            if (env >= 8'hFE) state <= ST_DECSUS;
                        end
                        ST_DECSUS: begin
                            exp_cnt <= exp_step ? 5'd0 : exp_cnt + 5'd1;
                            if (exp_step && (env > {sus, sus})) env <= env - 8'd1;
                        end
                        default: begin
                            exp_cnt <= exp_step ? 5'd0 : exp_cnt + 5'd1;
                            if (exp_step && (env != 8'd0)) env <= env - 8'd1;
                        end
                    endcase
                end
            end
        end
    end

    assign ENV_OUT = env;

    // Amplitude stage: flip the MSB to centre the waveform as signed, then
    // multiply by the zero-extended envelope.
    logic signed [20:0] p_q;
    logic signed [20:0] s_ext;
    logic signed [20:0] env_ext;
    logic               unused_p_bits;

    assign s_ext   = $signed({{9{~VOICE_IN[11]}}, ~VOICE_IN[11], VOICE_IN[10:0]});
    assign env_ext = $signed({13'd0, env});

    always_ff @(posedge CLK) begin
        if (RST) begin
            p_q    <= 21'sd0;
            OUTPUT <= 12'd0;
        end else begin
            p_q    <= s_ext * env_ext;
            OUTPUT <= p_q[19:8];
        end
    end

    assign unused_p_bits = ^{p_q[20], p_q[7:0]};

endmodule

// File: tb/tb_sid_envelope.sv
module tb_sid_envelope;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CLKen;
    logic        WR;
    logic [4:0]  ADDR;
    logic [7:0]  DATA;
    logic [11:0] VOICE_IN;
    wire  [7:0]  ENV_OUT;
    wire  [11:0] OUTPUT;

    sid_envelope #(.BASE_ADDR(0)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .CLKen    (CLKen),
        .WR       (WR),
        .ADDR     (ADDR),
        .DATA     (DATA),
        .VOICE_IN (VOICE_IN),
        .ENV_OUT  (ENV_OUT),
        .OUTPUT   (OUTPUT)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: -1 means "do not compare this field".
    string q_name[$];
    int    q_env[$];
    int    q_out[$];
    logic  chk_stb = 1'b0;

    string m_name;
    int    m_env;
    int    m_out;

    // Monitor: pops one expectation per sample strobe and compares.
    always @(posedge chk_stb) begin
        if (q_name.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL monitor_underflow: got sample strobe, want queued expectation");
        end else begin
            m_name = q_name.pop_front();
            m_env  = q_env.pop_front();
            m_out  = q_out.pop_front();
            if (m_env >= 0) begin
                checks++;
                if (ENV_OUT !== m_env[7:0]) begin
                    failures++;
                    $display("FAIL %s env: got %h want %h", m_name, ENV_OUT, m_env[7:0]);
                end
            end
            if (m_out >= 0) begin
                checks++;
                if (OUTPUT !== m_out[11:0]) begin
                    failures++;
                    $display("FAIL %s out: got %h want %h", m_name, OUTPUT, m_out[11:0]);
                end
            end
        end
    end

    task automatic expect_vals(input string name, input int e, input int o);
        q_name.push_back(name);
        q_env.push_back(e);
        q_out.push_back(o);
        chk_stb = 1'b1;
        #1;
        chk_stb = 1'b0;
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Exactly n CLK edges with CLKen high.
    task automatic run_en(input int n);
        CLKen = 1'b1;
        repeat (n) @(negedge CLK);
        CLKen = 1'b0;
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [7:0] d);
        WR   = 1'b1;
        ADDR = a;
        DATA = d;
        @(negedge CLK);
        WR   = 1'b0;
    endtask

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        RST      = 1'b1;
        CLKen    = 1'b0;
        WR       = 1'b0;
        ADDR     = 5'd0;
        DATA     = 8'd0;
        VOICE_IN = 12'h800;
        clk_n(2);
        RST = 1'b0;
        expect_vals("reset", 0, 0);

        run_en(10000);
        expect_vals("idle_10000", 0, -1);

        // Fresh reset so the rate counter phase starts at 0.
        RST = 1'b1;
        clk_n(1);
        RST = 1'b0;

        // Attack at rate 0 (9 CLKen per step), sustain 'hAA.
        wr_reg(5'd5, 8'h00);
        wr_reg(5'd6, 8'hA0);
        wr_reg(5'd4, 8'h01);
        run_en(1);    expect_vals("atk_edge",    8'h00, -1);
        run_en(7);    expect_vals("atk_8",       8'h00, -1);
        run_en(1);    expect_vals("atk_9",       8'h01, -1);
        run_en(2285); expect_vals("atk_2294",    8'hFE, -1);
        run_en(1);    expect_vals("atk_2295",    8'hFF, -1);

        // Decay at one step per tick above 94.
        run_en(9);    expect_vals("dec_first",   8'hFE, -1);
        run_en(756);  expect_vals("dec_sustain", 8'hAA, -1);
        run_en(5000); expect_vals("sus_hold",    8'hAA, -1);

        // Release from 'hAA; rate counter phase is 5 here, ticks every 9th CLKen.
        wr_reg(5'd6, 8'h00);
        wr_reg(5'd4, 8'h00);
        run_en(4);    expect_vals("rel_first",   8'hA9, -1);
        run_en(684);  expect_vals("rel_tick77",  8'h5D, -1);
        run_en(9);    expect_vals("rel_tick78",  8'h5D, -1);
        run_en(9);    expect_vals("rel_tick79",  8'h5C, -1);
        run_en(5327); expect_vals("rel_tick670", 8'h01, -1);
        run_en(1);    expect_vals("rel_zero",    8'h00, -1);
        run_en(2000); expect_vals("rel_nowrap",  8'h00, -1);

        // Attack to 'h40, release, retrigger: attack continues from 'h40.
        wr_reg(5'd4, 8'h01);
        run_en(1);    expect_vals("atk2_edge",   8'h00, -1);
        run_en(6);    expect_vals("atk2_first",  8'h01, -1);
        run_en(567);  expect_vals("atk2_40",     8'h40, -1);
        wr_reg(5'd4, 8'h00);
        run_en(1);    expect_vals("rel2_edge",   8'h40, -1);
        run_en(1);
        wr_reg(5'd4, 8'h01);
        run_en(1);    expect_vals("retrig_edge", 8'h40, -1);
        run_en(5);    expect_vals("retrig_hold", 8'h40, -1);
        run_en(1);    expect_vals("retrig_41",   8'h41, -1);

        // Amplitude at env 'h41: 'hC00 -> 1024 * 65 = 'h10400 -> 'h104.
        VOICE_IN = 12'hC00;
        clk_n(1);     expect_vals("amp41_lat1",  -1, 12'h000);
        clk_n(1);     expect_vals("amp41",       8'h41, 12'h104);

        run_en(1710); expect_vals("atk2_ff",     8'hFF, -1);
        VOICE_IN = 12'hFFF;
        clk_n(2);     expect_vals("amp_max",     8'hFF, 12'h7F7);
        VOICE_IN = 12'h000;
        clk_n(1);     expect_vals("amp_min_lat1", -1, 12'h7F7);
        clk_n(1);     expect_vals("amp_min",     -1, 12'h808);

        // Mid-operation reset clears envelope and pipeline.
        VOICE_IN = 12'hFFF;
        RST = 1'b1;
        clk_n(1);
        RST = 1'b0;
        expect_vals("mid_rst", 8'h00, 12'h000);
        clk_n(2);     expect_vals("amp_env0",    8'h00, 12'h000);

        #1;
        if (q_name.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q_name.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
